fp_scoreboard: RTL and testbench

//   Producer-side hazard tracker for the RV32IF pipeline. It records destination registers of
//   in-flight multi-cycle FPU ops (fdiv.s, fsqrt.s, fmadd.s family) from issue until writeback.
//   It stalls the ID stage on RAW, WAW and EX-stage load-use hazards that result forwarding cannot cover.
//   It sits between ID and EX, alongside the forwarding unit, and feeds the pipeline stall/bubble control.

---
 rtl/fp_scoreboard.sv | 95 +++++++++
 tb/tb_fp_scoreboard.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fp_scoreboard.sv
// Producer-side hazard tracker for multi-cycle FPU ops.
// Tracks pending destinations and stalls ID on RAW, WAW, load-use and full hazards.
module fp_scoreboard #(
  parameter int MAX_OUT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic       id_rs1_fp,
  input  logic       id_rs1_use,
  input  logic [4:0] id_rs2,
  input  logic       id_rs2_fp,
  input  logic       id_rs2_use,
  input  logic [4:0] id_rs3,
  input  logic       id_rs3_fp,
  input  logic       id_rs3_use,
  input  logic       issue_valid,
  input  logic [4:0] issue_rd,
  input  logic       issue_rd_fp,
  input  logic       cmpl_valid,
  input  logic [4:0] cmpl_rd,
  input  logic       cmpl_rd_fp,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       ex_rd_fp,
  output logic       stall,
  output logic       issue_fire,
  output logic [2:0] pending_count,
  output logic       sb_full,
  output logic       err_spurious
);

  localparam logic [2:0] LP_MAX = 3'(MAX_OUT);

  logic [63:0] r_pend;
  logic [2:0]  r_cnt;
  logic        r_err;

  logic w_raw1, w_raw2, w_raw3, w_raw;
  logic w_lu_en, w_lu1, w_lu2, w_lu3, w_lu;
  logic w_iss_x0, w_waw, w_full;
  logic w_set, w_clr, w_spur;

  // x0 is excluded explicitly even though it can never be set
  assign w_raw1 = id_rs1_use & r_pend[{id_rs1_fp, id_rs1}]
                & ~((id_rs1 == 5'd0) & ~id_rs1_fp);
  assign w_raw2 = id_rs2_use & r_pend[{id_rs2_fp, id_rs2}]
                & ~((id_rs2 == 5'd0) & ~id_rs2_fp);
  assign w_raw3 = id_rs3_use & r_pend[{id_rs3_fp, id_rs3}]
                & ~((id_rs3 == 5'd0) & ~id_rs3_fp);
  assign w_raw  = w_raw1 | w_raw2 | w_raw3;

  assign w_lu_en = ex_mem_read & ((ex_rd != 5'd0) | ex_rd_fp);
  assign w_lu1   = id_rs1_use & (id_rs1 == ex_rd)
                 & (id_rs1_fp == ex_rd_fp);
  assign w_lu2   = id_rs2_use & (id_rs2 == ex_rd)
                 & (id_rs2_fp == ex_rd_fp);
  assign w_lu3   = id_rs3_use & (id_rs3 == ex_rd)
                 & (id_rs3_fp == ex_rd_fp);
  assign w_lu    = w_lu_en & (w_lu1 | w_lu2 | w_lu3);

  assign w_iss_x0 = (issue_rd == 5'd0) & ~issue_rd_fp;
  assign w_waw    = issue_valid & ~w_iss_x0
                  & r_pend[{issue_rd_fp, issue_rd}];
  assign w_full   = issue_valid & (r_cnt == LP_MAX);

  assign stall      = w_raw | w_lu | w_waw | w_full;
  assign issue_fire = issue_valid & ~stall;

  assign w_set  = issue_fire & ~w_iss_x0;
  assign w_clr  = cmpl_valid & r_pend[{cmpl_rd_fp, cmpl_rd}];
  assign w_spur = cmpl_valid & ~r_pend[{cmpl_rd_fp, cmpl_rd}];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= '0;
      r_cnt  <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_set) r_pend[{issue_rd_fp, issue_rd}] <= 1'b1;
      if (w_clr) r_pend[{cmpl_rd_fp, cmpl_rd}] <= 1'b0;
      unique case ({w_set, w_clr})
        2'b10:   r_cnt <= r_cnt + 3'd1;
        2'b01:   r_cnt <= r_cnt - 3'd1;
        default: r_cnt <= r_cnt;
      endcase
      if (w_spur) r_err <= 1'b1;
    end
  end

  assign pending_count = r_cnt;
  assign sb_full       = (r_cnt == LP_MAX);
  assign err_spurious  = r_err;

endmodule

// File: tb/tb_fp_scoreboard.sv
// Table-driven bench for fp_scoreboard.
// Expected post-edge state is queued at drive time and popped after the edge.
module tb_fp_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, id_rs3;
  logic       id_rs1_fp, id_rs2_fp, id_rs3_fp;
  logic       id_rs1_use, id_rs2_use, id_rs3_use;
  logic       issue_valid, issue_rd_fp;
  logic [4:0] issue_rd;
  logic       cmpl_valid, cmpl_rd_fp;
  logic [4:0] cmpl_rd;
  logic       ex_mem_read, ex_rd_fp;
  logic [4:0] ex_rd;
  logic       stall, issue_fire, sb_full, err_spurious;
  logic [2:0] pending_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_scoreboard #(.MAX_OUT(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs1_fp(id_rs1_fp), .id_rs1_use(id_rs1_use),
    .id_rs2(id_rs2), .id_rs2_fp(id_rs2_fp), .id_rs2_use(id_rs2_use),
    .id_rs3(id_rs3), .id_rs3_fp(id_rs3_fp), .id_rs3_use(id_rs3_use),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rd_fp(issue_rd_fp),
    .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd), .cmpl_rd_fp(cmpl_rd_fp),
    .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .ex_rd_fp(ex_rd_fp),
    .stall(stall), .issue_fire(issue_fire),
    .pending_count(pending_count), .sb_full(sb_full),
    .err_spurious(err_spurious)
  );

  // operand/port code: [6]=use/valid, [5]=fp, [4:0]=reg
  typedef struct {
    string      nm;
    logic [6:0] r1, r2, r3, is, cm, ex;
    logic       st, fi;
    logic [2:0] cnt;
    logic       full, err;
  } vec_t;

  vec_t tbl[$];
  vec_t sbq[$];

  localparam logic [6:0] Z = 7'd0;

  function automatic logic [6:0] F(input logic [4:0] n);
    return {2'b11, n};
  endfunction

  function automatic logic [6:0] X(input logic [4:0] n);
    return {2'b10, n};
  endfunction

  function automatic vec_t mk(
    input string nm,
    input logic [6:0] r1, r2, r3, is, cm, ex,
    input logic st, fi,
    input logic [2:0] cnt,
    input logic full, err
  );
    vec_t v;
    v.nm = nm; v.r1 = r1; v.r2 = r2; v.r3 = r3;
    v.is = is; v.cm = cm; v.ex = ex;
    v.st = st; v.fi = fi; v.cnt = cnt;
    v.full = full; v.err = err;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [7:0] act,
                     input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_rs1_use = v.r1[6]; id_rs1_fp = v.r1[5]; id_rs1 = v.r1[4:0];
    id_rs2_use = v.r2[6]; id_rs2_fp = v.r2[5]; id_rs2 = v.r2[4:0];
    id_rs3_use = v.r3[6]; id_rs3_fp = v.r3[5]; id_rs3 = v.r3[4:0];
    issue_valid = v.is[6]; issue_rd_fp = v.is[5]; issue_rd = v.is[4:0];
    cmpl_valid = v.cm[6]; cmpl_rd_fp = v.cm[5]; cmpl_rd = v.cm[4:0];
    ex_mem_read = v.ex[6]; ex_rd_fp = v.ex[5]; ex_rd = v.ex[4:0];
  endtask

  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    drive(v);
    #1;
    chk({v.nm, ".stall"}, {7'd0, stall}, {7'd0, v.st});
    chk({v.nm, ".fire"}, {7'd0, issue_fire}, {7'd0, v.fi});
    sbq.push_back(v);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({e.nm, ".cnt"}, {5'd0, pending_count}, {5'd0, e.cnt});
    chk({e.nm, ".full"}, {7'd0, sb_full}, {7'd0, e.full});
    chk({e.nm, ".err"}, {7'd0, err_spurious}, {7'd0, e.err});
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    drive(mk("idle", Z, Z, Z, Z, Z, Z, 0, 0, 0, 0, 0));
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.cnt", {5'd0, pending_count}, 8'd0);
    chk("rst.full", {7'd0, sb_full}, 8'd0);
    chk("rst.err", {7'd0, err_spurious}, 8'd0);
    chk("rst.stall", {7'd0, stall}, 8'd0);
    chk("rst.fire", {7'd0, issue_fire}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // fdiv f5 then dependent fadd waits through completion
    tbl.push_back(mk("iss_f5", Z, Z, Z, F(5), Z, Z, 0, 1, 1, 0, 0));
    for (int c = 1; c <= 9; c++)
      tbl.push_back(mk($sformatf("raw_f5_c%0d", c),
                       F(5), Z, Z, Z, Z, Z, 1, 0, 1, 0, 0));
    tbl.push_back(mk("raw_cmpl_c10", F(5), Z, Z, Z, F(5), Z, 1, 0, 0, 0, 0));
    tbl.push_back(mk("raw_rel_c11", F(5), Z, Z, Z, Z, Z, 0, 0, 0, 0, 0));
    // load-use
    tbl.push_back(mk("lu_x7", X(7), Z, Z, Z, Z, X(7), 1, 0, 0, 0, 0));
    tbl.push_back(mk("lu_gone", X(7), Z, Z, Z, Z, Z, 0, 0, 0, 0, 0));
    tbl.push_back(mk("lu_x0", X(0), Z, Z, Z, Z, X(0), 0, 0, 0, 0, 0));
    tbl.push_back(mk("lu_fpmis", Z, X(7), Z, Z, Z, F(7), 0, 0, 0, 0, 0));
    tbl.push_back(mk("lu_rs3", Z, Z, F(7), Z, Z, F(7), 1, 0, 0, 0, 0));
    // fill to MAX_OUT
    tbl.push_back(mk("iss_f1", Z, Z, Z, F(1), Z, Z, 0, 1, 1, 0, 0));
    tbl.push_back(mk("iss_f2", Z, Z, Z, F(2), Z, Z, 0, 1, 2, 0, 0));
    tbl.push_back(mk("iss_f3", Z, Z, Z, F(3), Z, Z, 0, 1, 3, 0, 0));
    tbl.push_back(mk("iss_f4", Z, Z, Z, F(4), Z, Z, 0, 1, 4, 1, 0));
    tbl.push_back(mk("full_blk", Z, Z, Z, F(8), Z, Z, 1, 0, 4, 1, 0));
    // full is judged on the current count: completion does not bypass
    tbl.push_back(mk("full_cmpl", Z, Z, Z, F(6), F(1), Z, 1, 0, 3, 0, 0));
    tbl.push_back(mk("waw_f3", Z, Z, Z, F(3), Z, Z, 1, 0, 3, 0, 0));
    tbl.push_back(mk("iss_cmpl", Z, Z, Z, F(6), F(2), Z, 0, 1, 3, 0, 0));
    tbl.push_back(mk("spur_f9", Z, Z, Z, Z, F(9), Z, 0, 0, 3, 0, 1));
    tbl.push_back(mk("err_sticky", Z, Z, Z, Z, Z, Z, 0, 0, 3, 0, 1));
    tbl.push_back(mk("iss_x0", Z, Z, Z, X(0), Z, Z, 0, 1, 3, 0, 1));
    tbl.push_back(mk("raw_x0", X(0), Z, Z, Z, Z, Z, 0, 0, 3, 0, 1));
    tbl.push_back(mk("raw_f6_rs2", Z, F(6), Z, Z, Z, Z, 1, 0, 3, 0, 1));
    tbl.push_back(mk("unused_rs", 7'b0100110, Z, Z, Z, Z, Z,
                     0, 0, 3, 0, 1));
    tbl.push_back(mk("cmpl_f3", Z, Z, Z, Z, F(3), Z, 0, 0, 2, 0, 1));
    tbl.push_back(mk("iss_x10", Z, Z, Z, X(10), Z, Z, 0, 1, 3, 0, 1));
    tbl.push_back(mk("raw_x10", X(10), Z, Z, Z, Z, Z, 1, 0, 3, 0, 1));
    tbl.push_back(mk("no_f10", F(10), Z, Z, Z, Z, Z, 0, 0, 3, 0, 1));
    run_tbl();

    // asynchronous reset with three ops in flight
    @(negedge clk);
    drive(mk("idle", Z, Z, Z, Z, Z, Z, 0, 0, 0, 0, 0));
    #2 rst = 1'b1;
    #1;
    chk("arst.cnt", {5'd0, pending_count}, 8'd0);
    chk("arst.full", {7'd0, sb_full}, 8'd0);
    chk("arst.err", {7'd0, err_spurious}, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    tbl.push_back(mk("post_f4", F(4), Z, Z, Z, Z, Z, 0, 0, 0, 0, 0));
    tbl.push_back(mk("post_x10", Z, X(10), Z, Z, Z, Z, 0, 0, 0, 0, 0));
    tbl.push_back(mk("iss_f0", Z, Z, Z, F(0), Z, Z, 0, 1, 1, 0, 0));
    tbl.push_back(mk("raw_f0", F(0), Z, Z, Z, Z, Z, 1, 0, 1, 0, 0));
    run_tbl();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
